pipe_sched: RTL

PIPE_SCHED -- requirements
Module: pipe_sched

---
 rtl/pipe_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_sched.sv
// Pipeline scheduler: MDU busy counter plus F/D/E stall, flush and exception-redirect control.
// Optional PIPE_SCHED_PERF_EN adds a 32-bit stall cycle counter output (stall_cnt).
module pipe_sched #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall_hazard,
    input  logic       md_start_E,
    input  logic [1:0] md_type_E,
    input  logic       md_use_D,
    input  logic       exc_req,
    output logic       En_F,
    output logic       En_D,
    output logic       flush_E,
    output logic       req_F,
    output logic       md_busy,
    output logic [3:0] md_cnt
`ifdef PIPE_SCHED_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // A start cancelled by an exception in the same cycle never loads.
                if (md_start_E && !exc_req) begin
                    cnt_d   = md_type_E[1] ? DIV_LD : MULT_LD;
                    state_d = (cnt_d != '0) ? BUSY : IDLE;
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy = 1'b0;
        stall   = 1'b0;
        En_F    = 1'b1;
        En_D    = 1'b1;
        flush_E = 1'b0;
        req_F   = 1'b0;
        // Reset overrides every input so the pipeline free-runs cleanly out of reset.
        if (reset) begin
            md_busy = (cnt_q != '0) | md_start_E;
            stall   = stall_hazard | (md_use_D & md_busy);
            if (exc_req) begin
                req_F   = 1'b1;
                flush_E = 1'b1;
            end else if (stall) begin
                En_F    = 1'b0;
                En_D    = 1'b0;
                flush_E = 1'b1;
            end
        end
    end

    assign md_cnt = cnt_q;

`ifdef PIPE_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && !exc_req) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
